// File: rtl/vga_scanout.sv
// vga_scanout -- 640x480@60 VGA timing generator and framebuffer scanout.
//
// Runs from the 50 MHz system clock. A phase bit toggles every clock and
// produces a 25 MHz pixel enable. The horizontal and vertical counters advance
// on that enable. The framebuffer is 320x240 with 3-bit pixels, shown with
// 2x2 pixel doubling. Every VGA output is registered on the pixel enable, so
// the outputs trail the counters by one pixel period (2 clocks).
//
// Optional feature: define VGA_SCANOUT_BORDER_EN to draw a white one-pixel
// frame around the visible area. Left undefined, the RGB outputs carry
// framebuffer data only.
//
// Ports:
//   clock        in   50 MHz system clock
//   reset        in   synchronous, active-high
//   dpm_addr_B   out  framebuffer read address (dual-port memory, port B)
//   dpm_q_B      in   pixel {R,G,B}, valid one clock after the address
//   vga_clk      out  25 MHz pixel clock (the phase bit)
//   vga_hs       out  horizontal sync, active-low
//   vga_vs       out  vertical sync, active-low
//   vga_blank_n  out  high while the registered pixel is visible
//   vga_sync_n   out  composite sync, tied low
//   vga_r/g/b    out  8-bit colour channels
//   frame_start  out  one-clock pulse when the counters wrap to (0,0)
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_WIDTH = 320
) (
    input  logic        clock,
    input  logic        reset,
    output logic [16:0] dpm_addr_B,
    input  logic [2:0]  dpm_q_B,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_END = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEGIN  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS_END = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEGIN  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_SCANOUT_BORDER_EN
    localparam logic [H_W-1:0] H_VIS_LAST = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0] V_VIS_LAST = V_W'(V_ACTIVE - 1);
`endif

    // Row stride as a bit pattern: each set bit contributes one shifted row term.
    localparam logic [16:0] FB_W_BITS = 17'(FB_WIDTH);

    // A colour bit drives its whole 8-bit channel to full or zero intensity.
    function automatic logic [7:0] expand_bit(input logic b);
        return {8{b}};
    endfunction

    // Constant-coefficient multiply done as shift-add. With a 320 stride this
    // is (row << 8) + (row << 6) + col, so no multiplier is inferred.
    function automatic logic [16:0] fb_addr(input logic [16:0] row,
                                            input logic [16:0] col);
        logic [16:0] acc;
        acc = col;
        for (int i = 0; i < 17; i++) begin
            if (FB_W_BITS[i]) acc = acc + (row << i);
        end
        return acc;
    endfunction

    logic           phase_p0;
    logic           pix_en;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_last;
    logic           v_last;
    logic           active;
    logic [16:0]    row_x;
    logic [16:0]    col_x;

    logic           hs_d;
    logic           vs_d;
    logic [7:0]     r_d;
    logic [7:0]     g_d;
    logic [7:0]     b_d;

    logic           hs_p1;
    logic           vs_p1;
    logic           blank_n_p1;
    logic [7:0]     r_p1;
    logic [7:0]     g_p1;
    logic [7:0]     b_p1;
    logic           frame_start_p1;

    assign pix_en = phase_p0;
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign active = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);

    // ---- stage p0: pixel phase and raster counters ----
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_p0 <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else begin
            phase_p0 <= ~phase_p0;
            if (pix_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // The address stays stable through both clocks of a pixel period, so the
    // one-clock memory latency lands the pixel on dpm_q_B by the next pix_en.
    always_comb begin
        row_x      = 17'(v_cnt >> 1);
        col_x      = 17'(h_cnt >> 1);
        dpm_addr_B = active ? fb_addr(row_x, col_x) : '0;
    end

    always_comb begin
        hs_d = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
        vs_d = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
        r_d  = 8'h00;
        g_d  = 8'h00;
        b_d  = 8'h00;
        if (active) begin
            r_d = expand_bit(dpm_q_B[2]);
            g_d = expand_bit(dpm_q_B[1]);
            b_d = expand_bit(dpm_q_B[0]);
`ifdef VGA_SCANOUT_BORDER_EN
            if ((h_cnt == '0) || (h_cnt == H_VIS_LAST) ||
                (v_cnt == '0) || (v_cnt == V_VIS_LAST)) begin
                r_d = 8'hFF;
                g_d = 8'hFF;
                b_d = 8'hFF;
            end
`endif
        end
    end

    // ---- stage p1: registered VGA outputs, one pixel behind the counters ----
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_p1          <= 1'b1;
            vs_p1          <= 1'b1;
            blank_n_p1     <= 1'b0;
            r_p1           <= 8'h00;
            g_p1           <= 8'h00;
            b_p1           <= 8'h00;
            frame_start_p1 <= 1'b0;
        end else begin
            frame_start_p1 <= pix_en && h_last && v_last;
            if (pix_en) begin
                hs_p1      <= hs_d;
                vs_p1      <= vs_d;
                blank_n_p1 <= active;
                r_p1       <= r_d;
                g_p1       <= g_d;
                b_p1       <= b_d;
            end
        end
    end

    assign vga_clk     = phase_p0;
    assign vga_hs      = hs_p1;
    assign vga_vs      = vs_p1;
    assign vga_blank_n = blank_n_p1;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = r_p1;
    assign vga_g       = g_p1;
    assign vga_b       = b_p1;
    assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout. Two instances share clock and reset: one with
// full 640x480 timing, one with a shrunken raster so whole frames are short.
// Expected values are pushed to a scoreboard queue and popped when the DUT
// output is sampled (on the falling clock edge).
module tb_vga_scanout;

    // Full-size timing
    localparam int HA = 640, HF = 16, HSY = 96, HT = 800;
    localparam int VA = 480, VF = 10, VSY = 2, VT = 525;
    // Shrunken timing for the second instance
    localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 2, SHT = 24;
    localparam int SVA = 8, SVF = 1, SVS = 2, SVB = 1, SVT = 12;

    logic clock = 1'b0;
    always #10 clock = ~clock;

    logic reset = 1'b1;
    int   mem_mode = 0;   // 0: addr[2:0], 1: all ones, 2: all zeros

    logic [16:0] addr_d, addr_s;
    logic [2:0]  q_d = '0, q_s = '0;
    logic        clk_d, hs_d, vs_d, blank_d, sync_d, fs_d;
    logic [7:0]  r_d, g_d, b_d;
    logic        clk_s, hs_s, vs_s, blank_s, sync_s, fs_s;
    logic [7:0]  r_s, g_s, b_s;

    vga_scanout dut (
        .clock(clock), .reset(reset),
        .dpm_addr_B(addr_d), .dpm_q_B(q_d),
        .vga_clk(clk_d), .vga_hs(hs_d), .vga_vs(vs_d),
        .vga_blank_n(blank_d), .vga_sync_n(sync_d),
        .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
        .frame_start(fs_d)
    );

    vga_scanout #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .FB_WIDTH(320)
    ) dut_s (
        .clock(clock), .reset(reset),
        .dpm_addr_B(addr_s), .dpm_q_B(q_s),
        .vga_clk(clk_s), .vga_hs(hs_s), .vga_vs(vs_s),
        .vga_blank_n(blank_s), .vga_sync_n(sync_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .frame_start(fs_s)
    );

    function automatic logic [2:0] ref_q(input logic [16:0] a, input int mode);
        case (mode)
            1:       return 3'b111;
            2:       return 3'b000;
            default: return a[2:0];
        endcase
    endfunction

    // One-clock-latency memory models
    always @(posedge clock) begin
        q_d <= ref_q(addr_d, mem_mode);
        q_s <= ref_q(addr_s, mem_mode);
    end

    function automatic logic [31:0] ref_addr(input int h, input int v, input int ha, input int va);
        if (h < ha && v < va) return 32'((v / 2) * 320 + h / 2);
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_rgb(input int h, input int v, input int ha, input int va,
                                            input int mode);
        logic [2:0] q;
        if (!(h < ha && v < va)) return 32'd0;
`ifdef VGA_SCANOUT_BORDER_EN
        if (h == 0 || h == ha - 1 || v == 0 || v == va - 1) return 32'h00FF_FFFF;
`endif
        q = ref_q(17'(ref_addr(h, v, ha, va)), mode);
        return {8'h00, (q[2] ? 8'hFF : 8'h00), (q[1] ? 8'hFF : 8'h00), (q[0] ? 8'hFF : 8'h00)};
    endfunction

    string       tag_q[$];
    logic [31:0] val_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          t = 0;   // rising edges since reset release

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_chk++;
        if (val_q.size() == 0) begin
            $error("FAIL scoreboard-empty: observed %0h required an entry", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = val_q.pop_front();
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        t++;
        @(negedge clock);
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    // Outputs for pixel p appear after edge 2p+2; counters then hold pixel p+1.
    task automatic check_px(input int p);
        int h, v, hc, vc;
        h  = p % HT;        v  = (p / HT) % VT;
        hc = (p + 1) % HT;  vc = ((p + 1) / HT) % VT;
        push($sformatf("hs p%0d", p), 32'(!(h >= HA + HF && h < HA + HF + HSY)));
        push($sformatf("vs p%0d", p), 32'(!(v >= VA + VF && v < VA + VF + VSY)));
        push($sformatf("blank_n p%0d", p), 32'(h < HA && v < VA));
        push($sformatf("rgb p%0d", p), ref_rgb(h, v, HA, VA, mem_mode));
        push($sformatf("addr p%0d", p + 1), ref_addr(hc, vc, HA, VA));
        run_to(2 * p + 2);
        chk(32'(hs_d));
        chk(32'(vs_d));
        chk(32'(blank_d));
        chk({8'h00, r_d, g_d, b_d});
        chk(32'(addr_d));
    endtask

    task automatic check_px_s(input int p);
        int h, v;
        h = p % SHT;  v = (p / SHT) % SVT;
        push($sformatf("s blank_n p%0d", p), 32'(h < SHA && v < SVA));
        push($sformatf("s rgb p%0d", p), ref_rgb(h, v, SHA, SVA, mem_mode));
        run_to(2 * p + 2);
        chk(32'(blank_s));
        chk({8'h00, r_s, g_s, b_s});
    endtask

    task automatic check_reset_values(input string tag);
        push({tag, " hs"}, 32'd1);
        push({tag, " vs"}, 32'd1);
        push({tag, " blank_n"}, 32'd0);
        push({tag, " rgb"}, 32'd0);
        push({tag, " frame_start"}, 32'd0);
        push({tag, " vga_clk"}, 32'd0);
        push({tag, " addr"}, 32'd0);
        push({tag, " sync_n"}, 32'd0);
        chk(32'(hs_d));
        chk(32'(vs_d));
        chk(32'(blank_d));
        chk({8'h00, r_d, g_d, b_d});
        chk(32'(fs_d));
        chk(32'(clk_d));
        chk(32'(addr_d));
        chk(32'(sync_d));
    endtask

    initial begin
        int fall_t, cnt, vl, fsc;
        int blank_list[7];
        blank_list = '{640, 655, 656, 700, 751, 752, 799};

        // Reset state
        reset = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        push("s reset hs", 32'd1);
        push("s reset blank_n", 32'd0);
        chk(32'(hs_s));
        chk(32'(blank_s));

        // Release: first pix_en falls on the second edge
        reset = 1'b0;
        t = 0;
        tick();
        push("vga_clk t1", 32'd1);
        push("blank_n t1", 32'd0);
        chk(32'(clk_d));
        chk(32'(blank_d));
        check_px(0);
        push("vga_clk t2", 32'd0);
        chk(32'(clk_d));

        // Addressing and colour expansion
        check_px(1);
        check_px(2);
        check_px(10);
        check_px(11);

        // Blanking with the memory forced to 3'b111
        mem_mode = 1;
        check_px(600);
        check_px(639);
        foreach (blank_list[i]) check_px(blank_list[i]);
        mem_mode = 0;
        check_px(810);    // (10,1): addr 5
        check_px(1599);   // counters at (0,2): addr 320

        // Reset mid-line at h_cnt=300 on a pix_en edge
        run_to(3801);
        reset = 1'b1;
        tick();
        check_reset_values("midline");
        reset = 1'b0;
        t = 0;

        // Horizontal sync: first fall, low width, line period
        while (hs_d !== 1'b0 && t < 4000) tick();
        fall_t = t;
        push("hs first fall t", 32'd1314);
        chk(32'(fall_t));
        cnt = 0;
        while (hs_d === 1'b0 && cnt < 1000) begin
            tick();
            cnt++;
        end
        push("hs low clocks", 32'd192);
        chk(32'(cnt));
        while (hs_d !== 1'b0 && t < 6000) tick();
        push("line period", 32'd1600);
        chk(32'(t - fall_t));

        // Shrunken raster: border/data, address, frame timing
        reset = 1'b1;
        mem_mode = 2;
        tick();
        tick();
        reset = 1'b0;
        t = 0;
        check_px_s(8);     // (8,0)
        check_px_s(96);    // (0,4)
        check_px_s(104);   // (8,4)
        check_px_s(111);   // (15,4)
        run_to(366);       // counters at (15,7)
        push("s addr last", 32'd967);
        chk(32'(addr_s));

        while (fs_s !== 1'b1 && t < 2000) tick();
        push("s first frame_start t", 32'd576);
        chk(32'(t));
        vl = 0;
        fsc = 0;
        for (int n = 0; n < 576; n++) begin
            tick();
            if (vs_s === 1'b0) vl++;
            if (fs_s === 1'b1) fsc++;
        end
        push("s frame_start period", 32'd1);
        chk(32'(fs_s));
        push("s frame_start pulses", 32'd1);
        chk(32'(fsc));
        push("s vs low clocks", 32'd96);
        chk(32'(vl));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
